rom_arbiter: RTL
================

Name: rom_arbiter

Overview:
- Shares one synchronous single-port ROM (64 KB, registered read, 1-cycle latency, address 16 bits) between two requesters.
- Port A is the Z80 CPU fetch/read path and has priority. Port B is a secondary reader, such as a ROM-to-SDRAM copier or debug reader.
- The block sequences each access, drives the ROM address register, captures ROM data per port, and guarantees B forward progress with a starvation limit.

Parameters:
- AW, 16, ROM address width; must equal $clog2(ROM size in bytes).
- MAXWAIT, 4, number of consecutive A grants B may lose while requesting before B is forced to win; range 1..15.

Ports:
- clock   in   1    system clock; all state updates on its rising edge.
- reset   in   1    asynchronous, active-high reset.
- a_req   in   1    port A read request; level.
- a_addr  in   AW   port A byte address.
- a_ack   out  1    port A completion; 1-cycle pulse.
- a_q     out  8    port A read data; registered.
- b_req   in   1    port B read request; level.
- b_addr  in   AW   port B byte address.
- b_ack   out  1    port B completion; 1-cycle pulse.
- b_q     out  8    port B read data; registered.
- rom_a   out  AW   address to ROM; registered.
- rom_q   in   8    ROM data; valid one edge after rom_a is sampled.
- busy    out  1    high while state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high) forces: state=IDLE, rom_a=0, a_q=0, b_q=0, a_ack=0, b_ack=0, busy=0, owner=A, bwait=0. Any in-flight access is discarded and no ack is issued for it.
- FSM states:
  - IDLE: arbitrate. If any req is high, latch the winner's address into rom_a, record owner, and go to ADDR. Otherwise stay.
  - ADDR: ROM samples rom_a on this edge. Go to DATA.
  - DATA: rom_q is valid. Load owner_q <= rom_q and set owner_ack=1 for exactly one cycle. Go to IDLE.
- Latency: req sampled high at edge n in IDLE gives:
  - rom_a valid after edge n;
  - ack high and q valid after edge n+2;
  - ack low after edge n+3.
- Throughput is one access per 3 cycles.
- q holds its value until that port's next completion. The other port's completion never alters it.
- Arbitration, evaluated only in IDLE:
  - Only one req high: that port wins.
  - Both high and bwait < MAXWAIT: A wins, and bwait increments (saturating at MAXWAIT).
  - Both high and bwait == MAXWAIT: B wins.
  - Any B grant clears bwait to 0.
  - An A grant while b_req is low leaves bwait unchanged.
- Address is captured at grant. Changes on x_addr after grant are ignored for that access.
- Handshake:
  - Requester holds req and addr until it sees ack.
  - The ack cycle is an IDLE cycle, so req still high during it is taken as a new request. A requester wanting a single read deasserts req combinationally on ack.
  - If req drops mid-access, the access still completes: ack pulses and q updates.
- Never both acks in the same cycle; at most one access is in flight.
- busy = (state != IDLE).
- Address wrap: none. rom_a is the full AW bits and is passed straight through.

Test Plan:
- Reset mid-access:
  - Stimulus: assert reset during ADDR with a_req=1.
  - Required: all outputs read 0 immediately (asynchronously).
  - Required: no a_ack follows deassertion unless a_req is still high, in which case a fresh 3-cycle access runs.
- Single A read (ROM preloaded mem[0x0000]=0xF3, mem[0x3FFF]=0x5A, mem[0x8000]=0xC3):
  - Stimulus: a_req=1, a_addr=0x0000 sampled at edge n, a_req dropped on ack.
  - Required: rom_a=0x0000 after edge n; a_ack=1 for one cycle after edge n+2; a_q=0xF3; b_ack never pulses.
- Single B read:
  - Stimulus: b_addr=0x8000.
  - Required: b_q=0xC3 with the same 3-cycle timing.
  - Required: a_q keeps its previous value (0xF3).
- Contention with MAXWAIT=4:
  - Stimulus: a_req and b_req held high continuously with a_addr=0x0000, b_addr=0x3FFF.
  - Required: grant order A,A,A,A,B repeating.
  - Required: b_ack every 15 cycles with b_q=0x5A; a_q=0xF3.
- Address change after grant:
  - Stimulus: a_addr=0x3FFF at grant, switched to 0x8000 during ADDR.
  - Required: a_q=0x5A.
- Request withdrawn:
  - Stimulus: b_req deasserted one cycle after grant.
  - Required: b_ack still pulses once and b_q updates.
  - Required: next arbitration serves a pending a_req with no lost cycle.

Source files
------------

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a registered single-port ROM.
// Port A (CPU) has priority; port B is guaranteed a grant after MAXWAIT consecutive losses.
module rom_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned MAXWAIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_ack,
  output logic [7:0]    a_q,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic          b_ack,
  output logic [7:0]    b_q,
  output logic [AW-1:0] rom_a,
  input  logic [7:0]    rom_q,
  output logic          busy
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAXWAIT);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  typedef enum logic {
    OWN_A,
    OWN_B
  } owner_t;

  state_t        state;
  state_t        state_nx;
  owner_t        owner;
  owner_t        owner_nx;
  logic [3:0]    bwait;
  logic [3:0]    bwait_nx;
  logic [AW-1:0] rom_a_nx;
  logic          a_done;
  logic          b_done;

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    bwait_nx = bwait;
    rom_a_nx = rom_a;
    a_done   = 1'b0;
    b_done   = 1'b0;
    unique case (state)
      IDLE: begin
        // A wins unless B is also requesting and has already lost WAIT_LIMIT times.
        if (a_req && (!b_req || (bwait < WAIT_LIMIT))) begin
          owner_nx = OWN_A;
          rom_a_nx = a_addr;
          state_nx = ADDR;
          if (b_req) begin
            bwait_nx = (bwait == WAIT_LIMIT) ? bwait : bwait + 4'd1;
          end
        end else if (b_req) begin
          owner_nx = OWN_B;
          rom_a_nx = b_addr;
          bwait_nx = '0;
          state_nx = ADDR;
        end
      end
      ADDR: begin
        state_nx = DATA;
      end
      DATA: begin
        a_done   = (owner == OWN_A);
        b_done   = (owner == OWN_B);
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= OWN_A;
      bwait <= '0;
      rom_a <= '0;
      a_q   <= '0;
      b_q   <= '0;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      bwait <= bwait_nx;
      rom_a <= rom_a_nx;
      a_ack <= a_done;
      b_ack <= b_done;
      if (a_done) begin
        a_q <= rom_q;
      end
      if (b_done) begin
        b_q <= rom_q;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
